// File: rtl/enemy_manager_if.sv
// Controller-side bundle for enemy_manager: room load, combat hits, enemy
// status in; per-slot init, direction, damage and room status out.
interface enemy_manager_if #(
    parameter int unsigned NUM_ENEMIES = 5
);
    logic [2:0]               room;
    logic                     room_load;
    logic [NUM_ENEMIES-1:0]   hit;
    logic [NUM_ENEMIES-1:0]   enemy_active;
    logic [NUM_ENEMIES-1:0]   init_slot;
    logic [2:0]               init_room;
    logic [3*NUM_ENEMIES-1:0] dir_bus;
    logic [NUM_ENEMIES-1:0]   damage;
    logic [2:0]               alive_count;
    logic                     room_clear;
    logic                     busy;

    // Game/room controller side
    modport master (
        output room, room_load, hit, enemy_active,
        input  init_slot, init_room, dir_bus, damage, alive_count, room_clear, busy
    );

    // Enemy manager side
    modport slave (
        input  room, room_load, hit, enemy_active,
        output init_slot, init_room, dir_bus, damage, alive_count, room_clear, busy
    );
endinterface

// File: rtl/enemy_manager.sv
// Enemy slot manager: sequences per-slot initialization on room load,
// schedules LFSR-driven movement directions, gates hits into damage pulses
// and tracks live enemies to flag room clear.
module enemy_manager #(
    parameter int unsigned NUM_ENEMIES = 5,
    parameter int unsigned DIR_HOLD    = 32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_clk,
    enemy_manager_if.slave  bus
);

    localparam int unsigned K_W   = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam int unsigned TMR_W = 6;
    localparam int unsigned DIR_W = 3;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SETTLE,
        RUN
    } state_t;

    state_t                 state_q;
    logic [K_W-1:0]         k_q;
    logic                   settle_q;
    logic                   frame_clk_d;
    logic                   fe;
    logic [NUM_ENEMIES-1:0] init_slot_q;
    logic [NUM_ENEMIES-1:0] damage_q;
    logic [NUM_ENEMIES-1:0] hit_act;
    logic [NUM_ENEMIES-1:0] hit_act_d;
    logic [2:0]             init_room_q;
    logic [DIR_W-1:0]       dir_q   [NUM_ENEMIES];
    logic [TMR_W-1:0]       timer_q [NUM_ENEMIES];
    logic [CNT_W-1:0]       alive_q;
    logic [CNT_W-1:0]       alive_c;
    logic                   room_clear_q;
    logic                   busy_q;
    logic [15:0]            lfsr_q;
    logic                   lfsr_fb;
    logic [DIR_W-1:0]       draw;

    assign fe      = frame_clk & ~frame_clk_d;
    assign hit_act = bus.hit & bus.enemy_active;
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    // Bit 2 set means "stand still"; otherwise one of the four moves 1..4
    assign draw    = lfsr_q[2] ? '0 : DIR_W'(lfsr_q[1:0]) + DIR_W'(1);

    // Frame clock delay for rising-edge detection, same scheme as Enemy
    always_ff @(posedge Clk) begin
        frame_clk_d <= frame_clk;
    end

    // Population count of live enemies
    always_comb begin
        alive_c = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            alive_c = alive_c + CNT_W'(bus.enemy_active[i]);
        end
    end

    // Registered live count and hit history for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            alive_q   <= '0;
            hit_act_d <= '0;
        end else begin
            alive_q   <= alive_c;
            hit_act_d <= hit_act;
        end
    end

    // Main sequencer: room load, init walk, settle, run-time scheduling
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            settle_q     <= 1'b0;
            init_slot_q  <= '0;
            init_room_q  <= '0;
            damage_q     <= '0;
            room_clear_q <= 1'b0;
            busy_q       <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                dir_q[i]   <= '0;
                timer_q[i] <= '0;
            end
        end else begin
            damage_q <= '0;
            if (bus.room_load) begin
                // A load restarts the walk from slot 0; LFSR keeps running state
                state_q      <= INIT;
                k_q          <= '0;
                init_slot_q  <= NUM_ENEMIES'(1);
                init_room_q  <= bus.room;
                busy_q       <= 1'b1;
                room_clear_q <= 1'b0;
                for (int i = 0; i < NUM_ENEMIES; i++) begin
                    dir_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    INIT: begin
                        if (fe) begin
                            if (k_q == K_W'(NUM_ENEMIES - 1)) begin
                                state_q     <= SETTLE;
                                init_slot_q <= '0;
                                settle_q    <= 1'b0;
                            end else begin
                                k_q         <= k_q + K_W'(1);
                                init_slot_q <= init_slot_q << 1;
                            end
                        end
                    end
                    SETTLE: begin
                        // Staggered start so no two slots redraw on one frame
                        for (int i = 0; i < NUM_ENEMIES; i++) begin
                            timer_q[i] <= TMR_W'(i + 1);
                        end
                        if (settle_q) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                        end else begin
                            settle_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        damage_q <= hit_act & ~hit_act_d;
                        if (alive_q == '0) begin
                            room_clear_q <= 1'b1;
                        end
                        if (fe) begin
                            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
                            for (int i = 0; i < NUM_ENEMIES; i++) begin
                                if (bus.enemy_active[i]) begin
                                    if (timer_q[i] <= TMR_W'(1)) begin
                                        dir_q[i]   <= draw;
                                        timer_q[i] <= TMR_W'(DIR_HOLD);
                                    end else begin
                                        timer_q[i] <= timer_q[i] - TMR_W'(1);
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Inactive slots are held still regardless of their last draw
    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_dir
        assign bus.dir_bus[DIR_W*g +: DIR_W] = bus.enemy_active[g] ? dir_q[g] : '0;
    end

    assign bus.init_slot   = init_slot_q;
    assign bus.init_room   = init_room_q;
    assign bus.damage      = damage_q;
    assign bus.alive_count = alive_q;
    assign bus.room_clear  = room_clear_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_enemy_manager.sv
// Self-checking bench for enemy_manager.
module tb_enemy_manager;

    localparam int unsigned N    = 5;
    localparam int unsigned HOLD = 32;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;

    enemy_manager_if #(.NUM_ENEMIES(N)) bus ();

    enemy_manager #(
        .NUM_ENEMIES (N),
        .DIR_HOLD    (HOLD),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0] hit;
        logic [N-1:0] act;
        logic [N-1:0] dmg;
        int           alive;
    } vec_t;

    vec_t        tbl [12];
    logic [15:0] lfsr_seq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference LFSR: shift left, taps 15,13,12,10 into bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int draw_of(input logic [15:0] l);
        if (l[2]) return 0;
        return int'(l[1:0]) + 1;
    endfunction

    // Slot s draws on run-frame numbers s+1, s+1+HOLD, ...; value from LFSR before that frame
    function automatic int exp_dir(input int s, input int f);
        int first;
        int n;
        first = s + 1;
        if (f < first) return 0;
        n = first + ((f - first) / HOLD) * HOLD;
        return draw_of(lfsr_seq[n-1]);
    endfunction

    // Load a room, walk the five init frames and stop on the first RUN cycle
    task automatic run_init(input logic [2:0] r);
        bus.room      = r;
        bus.room_load = 1'b1;
        step();
        bus.room_load = 1'b0;
        check("load_init_slot", 32'(bus.init_slot), 32'h1);
        check("load_busy", 32'(bus.busy), 32'h1);
        check("load_init_room", 32'(bus.init_room), 32'(r));
        check("load_room_clear", 32'(bus.room_clear), 32'h0);
        for (int s = 0; s < N; s++) begin
            repeat (3) step();
            check("init_slot_hold", 32'(bus.init_slot), 32'h1 << s);
            frame_clk = 1'b1;
            check("init_slot_fe", 32'(bus.init_slot), 32'h1 << s);
            step();
            frame_clk = 1'b0;
            if (s < N - 1) begin
                check("init_slot_next", 32'(bus.init_slot), 32'h1 << (s + 1));
            end else begin
                check("settle_init_slot", 32'(bus.init_slot), 32'h0);
                check("settle_busy1", 32'(bus.busy), 32'h1);
            end
            check("init_dir", 32'(bus.dir_bus), 32'h0);
        end
        step();
        check("settle_busy2", 32'(bus.busy), 32'h1);
        step();
        check("run_busy", 32'(bus.busy), 32'h0);
        check("run_init_room", 32'(bus.init_room), 32'(r));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          f;
        int          pulses;
        int          range_ok;
        int          rc_exp;
        int          alive_now;
        logic [14:0] e;
        logic [14:0] mask;
        logic [N-1:0] ha_prev;
        logic [N-1:0] ha_new;
        logic [N-1:0] exp_dmg;
        logic [N-1:0] h;
        logic [N-1:0] a;

        tbl[0]  = '{5'b00000, 5'b11111, 5'b00000, 5};
        tbl[1]  = '{5'b01000, 5'b11111, 5'b01000, 5};
        tbl[2]  = '{5'b01000, 5'b11111, 5'b00000, 5};
        tbl[3]  = '{5'b01000, 5'b11111, 5'b00000, 5};
        tbl[4]  = '{5'b00000, 5'b11111, 5'b00000, 5};
        tbl[5]  = '{5'b00000, 5'b10111, 5'b00000, 4};
        tbl[6]  = '{5'b01000, 5'b10111, 5'b00000, 4};
        tbl[7]  = '{5'b01001, 5'b10111, 5'b00001, 4};
        tbl[8]  = '{5'b01001, 5'b10111, 5'b00000, 4};
        tbl[9]  = '{5'b00000, 5'b11111, 5'b00000, 5};
        tbl[10] = '{5'b00001, 5'b11111, 5'b00001, 5};
        tbl[11] = '{5'b10001, 5'b01111, 5'b00000, 4};

        lfsr_seq.push_back(16'hACE1);
        for (int i = 0; i < 100; i++) lfsr_seq.push_back(lfsr_next(lfsr_seq[i]));

        // Reset
        Reset            = 1'b1;
        frame_clk        = 1'b0;
        bus.room         = 3'd0;
        bus.room_load    = 1'b0;
        bus.hit          = '0;
        bus.enemy_active = '0;
        repeat (2) step();
        check("rst_init_slot", 32'(bus.init_slot), 32'h0);
        check("rst_dir", 32'(bus.dir_bus), 32'h0);
        check("rst_damage", 32'(bus.damage), 32'h0);
        check("rst_room_clear", 32'(bus.room_clear), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_alive", 32'(bus.alive_count), 32'h0);
        check("rst_init_room", 32'(bus.init_room), 32'h0);
        Reset = 1'b0;
        step();
        check("idle_busy", 32'(bus.busy), 32'h0);
        check("idle_alive", 32'(bus.alive_count), 32'h0);

        // Init walk for room 2, then direction schedule with all slots alive
        bus.enemy_active = 5'b11111;
        run_init(3'd2);
        check("run_dir_start", 32'(bus.dir_bus), 32'h0);
        check("run_alive", 32'(bus.alive_count), 32'd5);
        f = 0;
        for (int j = 0; j < 5 + 2 * HOLD + 3; j++) begin
            repeat ($urandom_range(1, 4)) step();
            frame_clk = 1'b1;
            step();
            f++;
            e = '0;
            range_ok = 1;
            for (int s = 0; s < N; s++) begin
                e[3*s +: 3] = 3'(exp_dir(s, f));
                if (int'(bus.dir_bus[3*s +: 3]) > 4) range_ok = 0;
            end
            check("dir_sched", 32'(bus.dir_bus), 32'(e));
            check("dir_range", 32'(range_ok), 32'h1);
            repeat ($urandom_range(0, 2)) step();
            frame_clk = 1'b0;
        end
        check("run_room_clear", 32'(bus.room_clear), 32'h0);

        // Table-driven hit/active vectors
        step();
        foreach (tbl[i]) begin
            bus.hit          = tbl[i].hit;
            bus.enemy_active = tbl[i].act;
            step();
            check("tbl_damage", 32'(bus.damage), 32'(tbl[i].dmg));
            check("tbl_alive", 32'(bus.alive_count), 32'(tbl[i].alive));
            if (!tbl[i].act[3]) check("tbl_dir3_mask", 32'(bus.dir_bus[11:9]), 32'h0);
        end

        // hit[3] held for 10 cycles must give a single pulse
        bus.hit          = '0;
        bus.enemy_active = 5'b11111;
        step();
        pulses = 0;
        bus.hit = 5'b01000;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.damage[3]) pulses++;
        end
        bus.hit = '0;
        step();
        if (bus.damage[3]) pulses++;
        check("held_hit_pulses", 32'(pulses), 32'h1);

        // Randomized hits and activity against an edge/popcount model
        ha_prev = '0;
        rc_exp  = 0;
        for (int j = 0; j < 300; j++) begin
            h = N'($urandom);
            a = N'(~($urandom & $urandom));
            bus.hit          = h;
            bus.enemy_active = a;
            ha_new  = h & a;
            exp_dmg = ha_new & ~ha_prev;
            ha_prev = ha_new;
            #1;
            mask = '0;
            for (int s = 0; s < N; s++) if (!a[s]) mask[3*s +: 3] = 3'b111;
            check("rnd_dir_mask", 32'(bus.dir_bus & mask), 32'h0);
            step();
            alive_now = $countones(a);
            check("rnd_damage", 32'(bus.damage), 32'(exp_dmg));
            check("rnd_alive", 32'(bus.alive_count), 32'(alive_now));
            check("rnd_room_clear", 32'(bus.room_clear), 32'(rc_exp));
            if (alive_now == 0) rc_exp = 1;
        end

        // Enemies die one by one, room clears, then an empty room
        bus.hit          = '0;
        bus.enemy_active = 5'b11111;
        step();
        run_init(3'd1);
        a = 5'b11111;
        for (int j = 0; j < N; j++) begin
            a[j] = 1'b0;
            bus.enemy_active = a;
            step();
            check("kill_alive", 32'(bus.alive_count), 32'(N - 1 - j));
        end
        check("clear_not_yet", 32'(bus.room_clear), 32'h0);
        for (int j = 0; j < 4; j++) begin
            step();
            check("clear_sticky", 32'(bus.room_clear), 32'h1);
        end
        run_init(3'd0);
        check("room0_first_run", 32'(bus.room_clear), 32'h0);
        step();
        check("room0_clear", 32'(bus.room_clear), 32'h1);

        // Reload mid-INIT with a coincident frame edge
        bus.enemy_active = 5'b11111;
        bus.room         = 3'd5;
        bus.room_load    = 1'b1;
        step();
        bus.room_load = 1'b0;
        for (int s = 0; s < 2; s++) begin
            repeat (2) step();
            frame_clk = 1'b1;
            step();
            frame_clk = 1'b0;
        end
        check("mid_init_k2", 32'(bus.init_slot), 32'h4);
        repeat (2) step();
        bus.room      = 3'd3;
        bus.room_load = 1'b1;
        frame_clk     = 1'b1;
        step();
        bus.room_load = 1'b0;
        frame_clk     = 1'b0;
        check("reload_init_slot", 32'(bus.init_slot), 32'h1);
        check("reload_init_room", 32'(bus.init_room), 32'h3);
        check("reload_busy", 32'(bus.busy), 32'h1);
        repeat (2) step();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        check("reload_first_fe", 32'(bus.init_slot), 32'h2);

        // Reset mid-INIT, then reset beating a coincident load
        Reset = 1'b1;
        step();
        check("mid_rst_init_slot", 32'(bus.init_slot), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_init_room", 32'(bus.init_room), 32'h0);
        check("mid_rst_dir", 32'(bus.dir_bus), 32'h0);
        check("mid_rst_damage", 32'(bus.damage), 32'h0);
        check("mid_rst_room_clear", 32'(bus.room_clear), 32'h0);
        Reset = 1'b0;
        repeat (2) step();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
        check("post_rst_idle", 32'(bus.init_slot), 32'h0);
        Reset         = 1'b1;
        bus.room      = 3'd6;
        bus.room_load = 1'b1;
        step();
        Reset         = 1'b0;
        bus.room_load = 1'b0;
        check("rst_wins_slot", 32'(bus.init_slot), 32'h0);
        check("rst_wins_room", 32'(bus.init_room), 32'h0);
        step();
        check("rst_wins_busy", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_manager.md
Name: enemy_manager

Overview:
- Controls the five Enemy slots of the current room.
- On a room load it runs the per-slot initialize sequence, one slot at a time, each slot aligned to a frame_clk edge.
- During play it schedules a movement direction per slot from a shared LFSR, gates hit requests into one-cycle damage pulses, and counts live enemies to flag room clear.
- Sits between the room/game controller and the Enemy instances; all Enemy initialize/dir/damage inputs are driven from here.

Parameters:
- NUM_ENEMIES, 5, number of enemy slots (slot i drives Enemy number i+1).
- DIR_HOLD, 32, frames a slot keeps a direction before redrawing (range 2..63).
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  vertical-sync frame clock; its rising edge is detected internally.
- room  in  3  current room index; sampled on room_load.
- room_load  in  1  one-cycle request to (re)populate enemies for room.
- hit  in  NUM_ENEMIES  per-slot hit request from combat logic; level-sensitive.
- enemy_active  in  NUM_ENEMIES  per-slot active flag returned by the Enemy instances.
- init_slot  out  NUM_ENEMIES  one-hot initialize, bit i to Enemy slot i.
- init_room  out  3  latched room, broadcast to all Enemy room inputs.
- dir_bus  out  3*NUM_ENEMIES  dir for slot i at bits [3i+2:3i]; 0 = still, 1 = left, 2 = right, 3 = down, 4 = up.
- damage  out  NUM_ENEMIES  one-cycle damage pulse per slot.
- alive_count  out  3  population count of enemy_active.
- room_clear  out  1  all enemies of the loaded room defeated.
- busy  out  1  high during INIT and SETTLE.

Behaviour:
- Frame edge: fe = frame_clk & ~frame_clk_d, where frame_clk_d is registered on Clk. This uses the same detection as Enemy, so edges are cycle-aligned.
- Reset (any state, mid-sequence included):
  - State IDLE.
  - init_slot, damage, dir_bus, room_clear, busy = 0.
  - init_room = 0; LFSR = LFSR_SEED; all timers = 0; slot counter = 0.
- IDLE: all outputs quiescent. room_load latches room into init_room, sets slot counter k = 0, goes to INIT.
- INIT:
  - init_slot = 1<<k; busy = 1; dir_bus = 0.
  - init_slot stays asserted through the cycle where fe = 1 (inclusive).
  - The next cycle: k increments and init_slot moves to the next bit.
  - After slot NUM_ENEMIES-1 sees fe, go to SETTLE. Total duration is NUM_ENEMIES frame edges.
- SETTLE:
  - 2 cycles, init_slot = 0, busy = 1, so that enemy_active reflects the new room.
  - Load timer[i] = i+1, which staggers redraws so no two slots expire on the same frame.
  - Then go to RUN.
- RUN:
  - busy = 0.
  - On each fe, the LFSR shifts left with feedback l[15]^l[13]^l[12]^l[10] into bit 0.
  - On each fe, every timer with enemy_active[i] decrements.
  - A timer decrementing from 1 to 0 draws dir_i from the pre-shift LFSR value: l[2] ? 0 : l[1:0]+1. The timer then reloads to DIR_HOLD.
  - Slots with enemy_active[i] = 0 force dir_i = 0 immediately (combinational mask on the registered dir).
  - If several timers expire together, they all take the same draw.
- Damage:
  - In RUN only, damage[i] pulses for exactly one cycle on the rising edge of (hit[i] & enemy_active[i]).
  - A held hit does not re-pulse until it deasserts and reasserts.
  - hit is ignored in IDLE, INIT and SETTLE.
- alive_count: registered popcount of enemy_active, updated every cycle in all states; 0 after reset until enemy_active changes.
- room_clear:
  - Set in RUN on the first cycle alive_count == 0, then sticky.
  - Cleared by room_load or Reset.
  - Room 0 (no enemies) therefore reaches room_clear 1 cycle after entering RUN.
- room_load in INIT, SETTLE or RUN:
  - Restarts INIT at k = 0 with the new room.
  - Clears room_clear, dir_bus and damage the same cycle.
  - The LFSR is not reset.
- room_load coincident with Reset: Reset wins.
- fe coincident with room_load: the load wins; that edge does not count toward the new INIT.

Test Plan:
- Reset → next cycle: init_slot=0, dir_bus=0, damage=0, room_clear=0, busy=0, alive_count=0; LFSR=16'hACE1.
- room=2, room_load pulse, frame edges every 100 cycles → init_slot goes 00001, 00010, 00100, 01000, 10000, each dropping the cycle after its fe. busy falls 2 cycles after the 5th fe; init_room=2 throughout.
- RUN, all 5 enemy_active=1, DIR_HOLD=32:
  - Slot 0 draws on the 1st fe, slot 4 on the 5th fe.
  - Each slot redraws exactly every 32 fe thereafter.
  - Dir values match a bench LFSR model from seed 16'hACE1 and are always within 0..4.
- hit[3] held high for 10 cycles with enemy_active[3]=1 → damage[3] high for exactly 1 cycle.
  - Bench then drops enemy_active[3] → dir_bus[11:9]=0 and alive_count=4.
  - hit[3] again → no pulse.
- Deassert enemy_active one slot at a time → alive_count 5→0; room_clear=1 the cycle after alive_count=0 and held; room_load with room=0 clears it. After init and settle, room_clear reasserts 1 cycle into RUN.
- room_load mid-INIT at k=2 → init_slot returns to 00001 the next cycle with the new init_room. Reset mid-INIT → IDLE, all outputs 0.
